ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- PS/2 keyboard receiver and key-state tracker; the upstream input stage that produces the 4-bit btnstate consumed by the plane-position block.
- Synchronises PS2C/PS2D to the 50 MHz system clock and deframes 11-bit PS/2 frames.
- Tracks make/break/extended prefixes and holds one level-sensitive bit per direction key.

Parameters:
- TIMEOUT_CYC, 50000, clk cycles without a PS2C falling edge before a partial frame is discarded (1 ms at 50 MHz).
- SYNC_STAGES, 2, flip-flop stages on PS2C and PS2D (minimum 2).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- PS2C  input  1  PS/2 clock from keyboard, asynchronous.
- PS2D  input  1  PS/2 data from keyboard, asynchronous.
- btnstate  output  4  held key state: [0] up, [1] down, [2] left, [3] right; 1 = pressed.
- scan_code  output  8  last accepted byte, including prefix bytes.
- scan_valid  output  1  one-cycle pulse when scan_code updates.
- frame_err  output  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset (rst_n=0, asynchronous): btnstate=0, scan_code=8'h00, scan_valid=0, frame_err=0. Receiver returns to IDLE. Prefix flags brk and ext clear. Timeout counter clears. Synchroniser flops preset to 1.
- Edge detect: fall = synced PS2C previous 1 and current 0. PS2D is sampled (synced) in the fall cycle.
- Receiver FSM:
  - IDLE: on fall with data=0 (start bit), go to DATA with bitcnt=0. On fall with data=1, stay in IDLE (no error).
  - DATA: shift data in LSB first. bitcnt increments 0..7. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on fall, the frame is good if data=1 and the parity check passes. Good frame: register the byte and go to IDLE. Bad frame: pulse frame_err, discard the byte, go to IDLE.
- Timeout: counter clears on every fall and while in IDLE. In any other state, when the counter reaches TIMEOUT_CYC-1, go to IDLE silently: no frame_err, prefix flags untouched.
- Latency: scan_valid, scan_code and btnstate all update in the cycle after the stop-bit fall, i.e. SYNC_STAGES+1 clk after the PS2C pin edge.
- Decoder, applied per accepted byte:
  - 8'hF0: set brk.
  - 8'hE0: set ext.
  - Any other byte is looked up together with ext:
    - ext=1: 75→up, 72→down, 6B→left, 74→right.
    - ext=0: 1D (W)→up, 1B (S)→down, 1C (A)→left, 23 (D)→right.
  - Mapped key: its btnstate bit = ~brk.
  - After any non-prefix byte, mapped or not, clear brk and ext.
  - All other codes (AA, FA, E1, …) leave btnstate unchanged.
- Multiple keys may be held simultaneously. Opposite directions may both be 1; arbitration belongs to the consumer.
- A break for a key not currently held writes 0 (idempotent).
- scan_valid pulses for prefix bytes as well.

Optional Feature:
- Macro PS2_PARITY_CHECK_EN.
- Defined: the frame is accepted only if the 8 data bits plus the parity bit have odd parity. A mismatch pulses frame_err and the byte is dropped.
- Undefined: the parity bit is shifted but ignored. Only a stop bit of 0 raises frame_err.

Test Plan:
- Send frames E0,75 then E0,F0,75 → btnstate goes 0000→0001→0000; scan_valid pulses 5 times; scan_code values E0,75,E0,F0,75.
- Send 1C then 23 held, then F0,1C → btnstate 0100→1100→1000.
- Frame 8'h1D with wrong parity bit:
  - With PS2_PARITY_CHECK_EN: frame_err pulses once, btnstate stays 0000, no scan_valid.
  - Without the macro: btnstate=0001.
- Start bit plus 4 data bits, then PS2C idle for 50000 cycles, then a full 8'h1B frame → no frame_err, btnstate=0010, scan_code=1B.
- Stop bit driven 0 on frame 8'h75 → frame_err pulses, btnstate unchanged.
- Press up (0001), assert rst_n=0 mid-way through the next frame → btnstate=0000 immediately. After release, a fresh 8'h72 frame decodes without ext, so btnstate stays 0000 (72 is unmapped without E0).

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises PS2C/PS2D, deframes 11-bit frames and
// tracks held direction keys. Optional macro: PS2_PARITY_CHECK_EN (odd-parity check).
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       PS2C,
  input  logic       PS2D,
  output logic [3:0] btnstate,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  logic [SYNC_STAGES-1:0] c_sync_q, c_sync_d;
  logic [SYNC_STAGES-1:0] d_sync_q, d_sync_d;
  logic                   c_prev_q, c_prev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   brk_q, brk_d;
  logic                   ext_q, ext_d;
  logic [3:0]             btn_q, btn_d;
  logic [7:0]             code_q, code_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;

  logic fall;
  logic din;
  logic parity_ok;
  logic good_byte;

  assign fall = c_prev_q & ~c_sync_q[SYNC_STAGES-1];
  assign din  = d_sync_q[SYNC_STAGES-1];

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;
  // Data plus parity must carry an odd number of ones.
  assign parity_ok = ^{shift_q, par_q};
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    c_sync_d  = {c_sync_q[SYNC_STAGES-2:0], PS2C};
    d_sync_d  = {d_sync_q[SYNC_STAGES-2:0], PS2D};
    c_prev_d  = c_sync_q[SYNC_STAGES-1];
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    btn_d     = btn_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    good_byte = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d     = par_q;
`endif

    if (fall || state_q == ST_IDLE) cnt_d = '0;
    else                            cnt_d = cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (fall && !din) begin
          state_d  = ST_DATA;
          bitcnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d  = {din, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
`ifdef PS2_PARITY_CHECK_EN
          par_d   = din;
`endif
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (din && parity_ok) good_byte = 1'b1;
          else                  err_d     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled partial frame is dropped quietly; prefix flags survive.
    if (!fall && state_q != ST_IDLE && cnt_q == CNT_LAST) state_d = ST_IDLE;

    if (good_byte) begin
      code_d  = shift_q;
      valid_d = 1'b1;
      if (shift_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else begin
        case ({ext_q, shift_q})
          9'h175, 9'h01D: btn_d[0] = ~brk_q;
          9'h172, 9'h01B: btn_d[1] = ~brk_q;
          9'h16B, 9'h01C: btn_d[2] = ~brk_q;
          9'h174, 9'h023: btn_d[3] = ~brk_q;
          default: ;
        endcase
        brk_d = 1'b0;
        ext_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Synchronisers preset to the idle-high bus level so reset release cannot fake a fall.
      c_sync_q <= '1;
      d_sync_q <= '1;
      c_prev_q <= 1'b1;
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      cnt_q    <= '0;
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      btn_q    <= '0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q    <= 1'b0;
`endif
    end else begin
      c_sync_q <= c_sync_d;
      d_sync_q <= d_sync_d;
      c_prev_q <= c_prev_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      btn_q    <= btn_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q    <= par_d;
`endif
    end
  end

  assign btnstate   = btn_q;
  assign scan_code  = code_q;
  assign scan_valid = valid_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: table of frames plus latency, timeout and reset sequences.
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int TO = 50000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       PS2C;
  logic       PS2D;
  logic [3:0] btnstate;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .PS2C      (PS2C),
    .PS2D      (PS2D),
    .btnstate  (btnstate),
    .scan_code (scan_code),
    .scan_valid(scan_valid),
    .frame_err (frame_err)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    logic [3:0] exp_btn;
    bit         exp_valid;
    bit         exp_err;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;
  int   total = 0;
  int   bad = 0;
  int   n_valid = 0;
  int   n_err = 0;
  logic [7:0] exp_code = 8'h00;

  always @(negedge clk) begin
    if (scan_valid === 1'b1) n_valid++;
    if (frame_err === 1'b1) n_err++;
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    PS2D = b;
    wait_clk(10);
    PS2C = 1'b0;
    wait_clk(20);
    PS2C = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(~bad_stop);
    PS2D = 1'b1;
    wait_clk(20);
  endtask

  task automatic add(input logic [7:0] code, input bit bp, input bit bs,
                     input logic [3:0] eb, input bit ev, input bit ee);
    vecs[nv] = '{code, bp, bs, eb, ev, ee};
    nv++;
  endtask

  // Sends one frame and compares state and pulse counts against the expected record.
  task automatic run_frame(input string tag, input logic [7:0] code, input bit bp, input bit bs,
                           input logic [3:0] eb, input bit ev, input bit ee);
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    send_frame(code, bp, bs);
    if (ev) exp_code = code;
    check({tag, "_btn"}, 32'(btnstate), 32'(eb));
    check({tag, "_code"}, 32'(scan_code), 32'(exp_code));
    check({tag, "_nvalid"}, n_valid - v0, ev ? 1 : 0);
    check({tag, "_nerr"}, n_err - e0, ee ? 1 : 0);
  endtask

  initial begin
    int v0, e0;
    logic [7:0] lc;

    add(8'hE0, 0, 0, 4'b0000, 1, 0);
    add(8'h75, 0, 0, 4'b0001, 1, 0);
    add(8'hE0, 0, 0, 4'b0001, 1, 0);
    add(8'hF0, 0, 0, 4'b0001, 1, 0);
    add(8'h75, 0, 0, 4'b0000, 1, 0);
    add(8'h1C, 0, 0, 4'b0100, 1, 0);
    add(8'h23, 0, 0, 4'b1100, 1, 0);
    add(8'hF0, 0, 0, 4'b1100, 1, 0);
    add(8'h1C, 0, 0, 4'b1000, 1, 0);
    add(8'hF0, 0, 0, 4'b1000, 1, 0);
    add(8'h23, 0, 0, 4'b0000, 1, 0);
    add(8'hE0, 0, 0, 4'b0000, 1, 0);
    add(8'hAA, 0, 0, 4'b0000, 1, 0);
    add(8'h75, 0, 0, 4'b0000, 1, 0);
    add(8'h1D, 0, 0, 4'b0001, 1, 0);
    add(8'h75, 0, 1, 4'b0001, 0, 1);
    add(8'hF0, 0, 0, 4'b0001, 1, 0);
    add(8'h1D, 0, 0, 4'b0000, 1, 0);
    add(8'hF0, 0, 0, 4'b0000, 1, 0);
    add(8'h1B, 0, 0, 4'b0000, 1, 0);
    add(8'h1B, 0, 0, 4'b0010, 1, 0);
    add(8'hE0, 0, 0, 4'b0010, 1, 0);
    add(8'h6B, 0, 0, 4'b0110, 1, 0);
    add(8'hE0, 0, 0, 4'b0110, 1, 0);
    add(8'hF0, 0, 0, 4'b0110, 1, 0);
    add(8'h72, 0, 0, 4'b0100, 1, 0);
    add(8'hE0, 0, 0, 4'b0100, 1, 0);
    add(8'hF0, 0, 0, 4'b0100, 1, 0);
    add(8'h6B, 0, 0, 4'b0000, 1, 0);
`ifdef PS2_PARITY_CHECK_EN
    add(8'h1D, 1, 0, 4'b0000, 0, 1);
    add(8'hF0, 0, 0, 4'b0000, 1, 0);
`else
    add(8'h1D, 1, 0, 4'b0001, 1, 0);
    add(8'hF0, 0, 0, 4'b0001, 1, 0);
`endif
    add(8'h1D, 0, 0, 4'b0000, 1, 0);
    add(8'hE0, 0, 0, 4'b0000, 1, 0);
    add(8'h74, 0, 0, 4'b1000, 1, 0);
    add(8'hE0, 0, 0, 4'b1000, 1, 0);
    add(8'hF0, 0, 0, 4'b1000, 1, 0);
    add(8'h74, 0, 0, 4'b0000, 1, 0);

    rst_n = 1'b0;
    PS2C  = 1'b1;
    PS2D  = 1'b1;
    wait_clk(3);
    check("reset_btn", 32'(btnstate), 32'h0);
    check("reset_code", 32'(scan_code), 32'h0);
    check("reset_valid", 32'(scan_valid), 32'h0);
    check("reset_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    wait_clk(5);

    for (int i = 0; i < nv; i++)
      run_frame($sformatf("row%0d", i), vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop,
                vecs[i].exp_btn, vecs[i].exp_valid, vecs[i].exp_err);

    // Latency: outputs move exactly three clocks after the stop-bit PS2C fall.
    lc = 8'h23;
    v0 = n_valid;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(lc[i]);
    ps2_bit(~^lc);
    PS2D = 1'b1;
    wait_clk(10);
    PS2C = 1'b0;
    wait_clk(2);
    check("lat_early_valid", 32'(scan_valid), 32'h0);
    check("lat_early_btn", 32'(btnstate), 32'h0);
    wait_clk(1);
    check("lat_valid", 32'(scan_valid), 32'h1);
    check("lat_btn", 32'(btnstate), 32'h8);
    check("lat_code", 32'(scan_code), 32'h23);
    wait_clk(1);
    check("lat_pulse_width", 32'(scan_valid), 32'h0);
    wait_clk(18);
    PS2C = 1'b1;
    wait_clk(30);
    check("lat_nvalid", n_valid - v0, 1);
    exp_code = 8'h23;
    run_frame("lat_rel_f0", 8'hF0, 0, 0, 4'b1000, 1, 0);
    run_frame("lat_rel_23", 8'h23, 0, 0, 4'b0000, 1, 0);

    // Timeout: a stalled partial frame is discarded without an error.
    v0 = n_valid;
    e0 = n_err;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    PS2D = 1'b1;
    wait_clk(TO + 20);
    check("to_nerr", n_err - e0, 0);
    check("to_nvalid", n_valid - v0, 0);
    run_frame("to_1b", 8'h1B, 0, 0, 4'b0010, 1, 0);
    run_frame("to_rel_f0", 8'hF0, 0, 0, 4'b0010, 1, 0);
    run_frame("to_rel_1b", 8'h1B, 0, 0, 4'b0000, 1, 0);

    // Reset mid-frame clears keys and the pending E0 prefix.
    run_frame("rs_1d", 8'h1D, 0, 0, 4'b0001, 1, 0);
    run_frame("rs_e0", 8'hE0, 0, 0, 4'b0001, 1, 0);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    rst_n = 1'b0;
    #1;
    check("rs_async_btn", 32'(btnstate), 32'h0);
    check("rs_async_code", 32'(scan_code), 32'h0);
    wait_clk(3);
    rst_n = 1'b1;
    PS2D  = 1'b1;
    wait_clk(5);
    exp_code = 8'h00;
    run_frame("rs_72", 8'h72, 0, 0, 4'b0000, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
